skinny_sbox8_share_encoder: RTL and testbench
=============================================

// Module: skinny_sbox8_share_encoder
// PURPOSE
// - Transmit side of the masked S-box datapath: takes plain bytes, splits each into d+1 Boolean shares, emits them with fresh DOM randomness r.
// - Feeds skinny_sbox8_domd_* instances (share layout {share_d,...,share_0}, share_0 = x ^ all masks, shares 1..d = masks).
// - Internal seeded PRNG; valid/ready handshake on both sides; 1-cycle latency, 1 byte/cycle throughput.
// PARAMETERS
// - d        1             masking order; shares = d+1; r width = 8*d*(d+1)/2
// - SEED     32'hACE12468  base PRNG seed applied at reset
// - WARMUP   16            PRNG steps after reset/reseed before first accept (>=1)
// PORTS
// - clk          in   1               clock, rising edge
// - rst          in   1               asynchronous, active-high reset
// - in_valid     in   1               plain byte valid
// - in_ready     out  1               encoder accepts this cycle
// - in_data      in   8               plain byte x
// - out_valid    out  1               shares/r valid
// - out_ready    in   1               consumer accepts this cycle
// - out_shares   out  8*(d+1)         share i at [8i+7:8i]; XOR of all shares == x
// - out_r        out  8*d*(d+1)/2     fresh DOM randomness for the S-box
// BEHAVIOUR
// - Reset (async): out_valid=0, out_shares=0, out_r=0, in_ready=0, state=WARM, warm counter=0, PRNG lanes = seeds.
// - PRNG: NL = d + d*(d+1)/2 lanes, each a 32-bit Fibonacci LFSR, taps x^32+x^22+x^2+x+1, advanced 8 steps per step event; lane output = low byte after advance.
// - Lane i seed = SEED ^ (i * 32'h9E3779B9); all-zero seed replaced by 32'h1 (LFSR never holds 0).
// - Lanes 0..d-1 give masks m_1..m_d; lanes d..NL-1 give out_r bytes in order.
// - FSM WARM: PRNG steps every cycle; in_ready=0; after WARMUP steps -> RUN.
// - FSM RUN: in_ready = !out_valid | out_ready (bypass: accept while draining same cycle).
// - Accept (in_valid & in_ready): PRNG steps once; next cycle out_valid=1, share_0 = x ^ m_1 ^...^ m_d, share_j = m_j, out_r = r lanes; uses post-step lane bytes.
// - No accept in RUN: PRNG holds (deterministic sequence per accepted byte).
// - out_valid & !out_ready: out_shares/out_r held stable, no PRNG step, in_ready=0.
// - out_valid & out_ready & !accept: out_valid->0; data regs keep old values.
// - Reset mid-transfer: pending output dropped, re-warms; PRNG sequence restarts identical to power-up.
// - in_valid ignored in WARM; in_data never appears unmasked on any output register.
// CONFIGURATION
// - SKINNY_ENC_RESEED_EN defined: extra ports seed_load (in,1) and seed_in (in,32); seed_load=1 reloads lanes from seed_in (same per-lane rule), clears out_valid, warm counter=0, state->WARM; overrides a same-cycle accept (accept suppressed since in_ready=0 in that cycle).
// - Not defined: ports absent; seed only from SEED parameter at reset.
// STRUCTURE
// - skinny_sca_pkg: LFSR tap constant, lane seed constant 32'h9E3779B9, functions nlanes(d), rwidth(d), lfsr32_step8().
// - Sub-module skinny_lfsr32_x8: one lane (seed, load, step, byte out); encoder instantiates NL via generate.
// - Top: FSM + warm counter, output register slice, share XOR tree.
// TESTING
// - Reset: rst=1 then release -> all outputs 0, in_ready stays 0 exactly WARMUP=16 cycles, then 1.
// - Exhaustive: d=1, bytes 0x00..0xFF, out_ready=1 -> out_shares[7:0]^out_shares[15:8]==x each, 256 transfers in 256 cycles after first; masks/r match pkg model.
// - Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> outputs bit-stable, in_ready=0, no PRNG step; release -> next byte masked with next model value.
// - Mid-run reset: rst pulse while out_valid=1 -> out_valid=0 immediately; re-warm; first mask equals first mask after power-up.
// - d=2: byte 0xA5 -> XOR of 3 shares == 0xA5, out_r 24 bits == lanes 2..4 of model.
// - SKINNY_ENC_RESEED_EN: seed_load with seed_in=32'h0 -> lanes seeded nonzero, WARM for 16 cycles, sequence matches model for that seed.

Source files
------------

// File: rtl/skinny_sca_pkg.sv
// Shared constants and helpers for the masked SKINNY S-box datapath:
// LFSR taps, lane seed derivation and share/randomness sizing.
package skinny_sca_pkg;

    // x^32 + x^22 + x^2 + x + 1 : feedback from state bits 31, 21, 1, 0
    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [31:0] LANE_SEED_K = 32'h9E37_79B9;

    typedef enum logic {ST_WARM, ST_RUN} enc_state_t;

    function automatic int nlanes(input int dd);
        return dd + (dd * (dd + 1)) / 2;
    endfunction

    function automatic int rwidth(input int dd);
        return 8 * ((dd * (dd + 1)) / 2);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is forced to 1.
    function automatic logic [31:0] lane_seed(input logic [31:0] base, input int unsigned idx);
        logic [31:0] s;
        s = base ^ (idx * LANE_SEED_K);
        if (s == 32'h0)
            s = 32'h1;
        return s;
    endfunction

    function automatic logic [31:0] lfsr32_step8(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < 8; k++)
            t = {t[30:0], ^(t & LFSR_TAPS)};
        return t;
    endfunction

endpackage

// File: rtl/skinny_lfsr32_x8.sv
// One PRNG lane: 32-bit Fibonacci LFSR advanced 8 bits per step.
// byte_next is the lane byte that becomes current if step is taken now.
module skinny_lfsr32_x8
    import skinny_sca_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_seed,
    input  logic        step,
    output logic [7:0]  byte_next
);

    logic [31:0] state_reg;
    logic [31:0] state_next;

    assign state_next = lfsr32_step8(state_reg);
    assign byte_next  = state_next[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= RESET_SEED;
        else if (load)
            state_reg <= load_seed;
        else if (step)
            state_reg <= state_next;
    end

endmodule

// File: rtl/skinny_sbox8_share_encoder.sv
// Splits plain bytes into d+1 Boolean shares plus fresh DOM randomness.
// Optional runtime reseeding is enabled by defining SKINNY_ENC_RESEED_EN.
module skinny_sbox8_share_encoder
    import skinny_sca_pkg::*;
#(
    parameter int          d      = 1,
    parameter logic [31:0] SEED   = 32'hACE12468,
    parameter int          WARMUP = 16
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef SKINNY_ENC_RESEED_EN
    input  logic                   seed_load,
    input  logic [31:0]            seed_in,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*(d+1)-1:0]     out_shares,
    output logic [rwidth(d)-1:0]   out_r
);

    localparam int NL = nlanes(d);
    localparam int NR = NL - d;
    localparam int CW = $clog2(WARMUP + 1);

    enc_state_t              state_reg;
    logic [CW-1:0]           warm_cnt_reg;
    logic                    out_valid_reg;
    logic [8*(d+1)-1:0]      shares_reg;
    logic [rwidth(d)-1:0]    r_reg;

    logic                    reseed;
    logic [31:0]             reseed_value;
    logic                    accept;
    logic                    lane_step;
    logic [7:0]              lane_byte [NL];
    logic [7:0]              mask_xor;
    logic [8*(d+1)-1:0]      shares_next;
    logic [rwidth(d)-1:0]    r_next;

`ifdef SKINNY_ENC_RESEED_EN
    assign reseed       = seed_load;
    assign reseed_value = seed_in;
`else
    assign reseed       = 1'b0;
    assign reseed_value = SEED;
`endif

    // Ready bypass lets a new byte enter while the current one drains.
    assign in_ready  = (state_reg == ST_RUN) && (!out_valid_reg || out_ready) && !reseed;
    assign accept    = in_valid && in_ready;
    assign lane_step = !reseed && ((state_reg == ST_WARM) || accept);

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            skinny_lfsr32_x8 #(
                .RESET_SEED(lane_seed(SEED, gi))
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .load      (reseed),
                .load_seed (lane_seed(reseed_value, gi)),
                .step      (lane_step),
                .byte_next (lane_byte[gi])
            );
        end
        for (genvar gi = 0; gi < d; gi++) begin : g_mask_share
            assign shares_next[8*(gi+1) +: 8] = lane_byte[gi];
        end
        for (genvar gi = 0; gi < NR; gi++) begin : g_rand
            assign r_next[8*gi +: 8] = lane_byte[d+gi];
        end
    endgenerate

    always_comb begin
        mask_xor = 8'h00;
        for (int i = 0; i < d; i++)
            mask_xor = mask_xor ^ lane_byte[i];
    end

    // in_data is only ever combined with masks before reaching a register.
    assign shares_next[7:0] = in_data ^ mask_xor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_WARM;
            warm_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            shares_reg    <= '0;
            r_reg         <= '0;
        end else if (reseed) begin
            state_reg     <= ST_WARM;
            warm_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_WARM: begin
                    if (warm_cnt_reg == CW'(WARMUP - 1)) begin
                        state_reg    <= ST_RUN;
                        warm_cnt_reg <= '0;
                    end else begin
                        warm_cnt_reg <= warm_cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        out_valid_reg <= 1'b1;
                        shares_reg    <= shares_next;
                        r_reg         <= r_next;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_WARM;
            endcase
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_shares = shares_reg;
    assign out_r      = r_reg;

endmodule

// File: tb/tb_skinny_sbox8_share_encoder.sv
// Directed + randomized bench for the share encoder (d=1 main DUT, d=2 side DUT)
// against a bit-serial LFSR reference model.
module tb_skinny_sbox8_share_encoder;

    localparam logic [31:0] SEED = 32'hACE12468;
    localparam logic [31:0] GOLD = 32'h9E3779B9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, out_valid;
    logic [15:0] out_shares;
    logic [7:0]  out_r;

    logic        in_valid2 = 1'b0;
    logic [7:0]  in_data2 = 8'h00;
    logic        in_ready2, out_valid2;
    logic [23:0] out_shares2, out_r2;

    logic        seed_load = 1'b0, seed_load2 = 1'b0;
    logic [31:0] seed_in = 32'h0, seed_in2 = 32'h0;

    int errors = 0;
    int checks = 0;

    logic [31:0] lane1 [2];
    logic [31:0] lane2 [5];
    logic        exp_valid;
    logic [15:0] exp_shares;
    logic [7:0]  exp_r;

    always #5 clk = ~clk;

    skinny_sbox8_share_encoder #(.d(1), .SEED(SEED), .WARMUP(16)) dut (
        .clk(clk), .rst(rst),
`ifdef SKINNY_ENC_RESEED_EN
        .seed_load(seed_load), .seed_in(seed_in),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_shares(out_shares), .out_r(out_r)
    );

    skinny_sbox8_share_encoder #(.d(2), .SEED(SEED), .WARMUP(16)) dut2 (
        .clk(clk), .rst(rst),
`ifdef SKINNY_ENC_RESEED_EN
        .seed_load(seed_load2), .seed_in(seed_in2),
`endif
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_shares(out_shares2), .out_r(out_r2)
    );

    // Reference LFSR: shift in one feedback bit at a time, where the
    // feedback is the sum of the x^32, x^22, x^2 and x^1 terms.
    function automatic logic [31:0] adv8(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < 8; k++)
            t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
        return t;
    endfunction

    function automatic logic [31:0] seed_of(input logic [31:0] base, input int i);
        logic [31:0] s;
        s = base ^ (GOLD * i);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    task automatic model1_reset(input logic [31:0] base);
        for (int i = 0; i < 2; i++) lane1[i] = seed_of(base, i);
    endtask

    task automatic model1_step();
        for (int i = 0; i < 2; i++) lane1[i] = adv8(lane1[i]);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called #1 after a rising edge while the DUT is warming.
    task automatic warm_check(input string tag);
        int cnt;
        cnt = 0;
        while (in_ready !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk(tag, 64'(cnt), 64'd16);
        for (int k = 0; k < 16; k++) model1_step();
    endtask

    // One d=1 transfer cycle: drive, check ready, clock, check registered outputs.
    task automatic cycle1(input logic iv, input logic [7:0] x, input logic orr);
        logic acc;
        in_valid = iv; in_data = x; out_ready = orr;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!exp_valid || orr));
        acc = iv && (!exp_valid || orr);
        @(posedge clk); #1;
        if (acc) begin
            model1_step();
            exp_valid  = 1'b1;
            exp_shares = {lane1[0][7:0], x ^ lane1[0][7:0]};
            exp_r      = lane1[1][7:0];
        end else if (orr) begin
            exp_valid = 1'b0;
        end
        chk("out", {out_valid, out_shares, out_r}, {exp_valid, exp_shares, exp_r});
    endtask

    initial begin
        logic [7:0] xs;
        exp_valid = 1'b0; exp_shares = '0; exp_r = '0;
        model1_reset(SEED);

        // Power-up reset and warm-up length
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {in_ready, out_valid, out_shares, out_r}, 64'd0);
        chk("reset_outputs2", {in_ready2, out_valid2, out_shares2, out_r2}, 64'd0);
        rst = 1'b0;
        warm_check("warm_cycles");

        // d=2: one byte, three shares and 24 bits of randomness
        for (int i = 0; i < 5; i++) begin
            lane2[i] = seed_of(SEED, i);
            for (int k = 0; k < 17; k++) lane2[i] = adv8(lane2[i]);
        end
        in_valid2 = 1'b1; in_data2 = 8'hA5;
        #1;
        chk("d2_in_ready", 64'(in_ready2), 64'd1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        chk("d2_valid", 64'(out_valid2), 64'd1);
        chk("d2_xor", 64'(out_shares2[7:0] ^ out_shares2[15:8] ^ out_shares2[23:16]), 64'hA5);
        chk("d2_masks", 64'(out_shares2[23:8]), 64'({lane2[1][7:0], lane2[0][7:0]}));
        chk("d2_r", 64'(out_r2), 64'({lane2[4][7:0], lane2[3][7:0], lane2[2][7:0]}));

        // Exhaustive byte sweep at full throughput
        for (int x = 0; x < 256; x++) cycle1(1'b1, 8'(x), 1'b1);

        // Backpressure: five stalled cycles, then release
        for (int k = 0; k < 5; k++) cycle1(1'b1, 8'(8'h10 + k), 1'b0);
        cycle1(1'b1, 8'hC3, 1'b1);

        // Asynchronous reset while a transfer is pending
        rst = 1'b1;
        #1;
        chk("async_reset", {out_valid, out_shares, out_r}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model1_reset(SEED);
        exp_valid = 1'b0; exp_shares = '0; exp_r = '0;
        in_valid = 1'b1; in_data = 8'h3C;
        warm_check("rewarm_cycles");
        chk("rewarm_idle", {out_valid, out_shares, out_r}, 64'd0);
        cycle1(1'b1, 8'h5A, 1'b1);

        // Randomized valid/ready traffic
        for (int n = 0; n < 400; n++) begin
            xs = 8'($urandom);
            cycle1(1'($urandom_range(0, 1)), xs, ($urandom_range(0, 3) != 0));
        end

`ifdef SKINNY_ENC_RESEED_EN
        // Reseed with zero overrides a same-cycle accept
        in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        seed_load = 1'b1; seed_in = 32'h0;
        #1;
        chk("reseed_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        seed_load = 1'b0;
        exp_valid = 1'b0;
        model1_reset(32'h0);
        chk("reseed_out", {out_valid, out_shares, out_r}, {exp_valid, exp_shares, exp_r});
        warm_check("reseed_warm");
        for (int n = 0; n < 8; n++) cycle1(1'b1, 8'(n * 37), 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
